// File: rtl/ofdm_sync_pkg.sv
// Shared OFDM synchronisation types and constants, used by the short- and long-preamble stages.
`timescale 1ns/1ps
package ofdm_sync_pkg;

  // Beats from a sample entering until the FSM state reflects its hit decision
  localparam int unsigned METRIC_DELAY = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PLATEAU = 2'd1,
    S_MARK    = 2'd2,
    S_HOLDOFF = 2'd3
  } sync_state_t;

  // Accumulator width: a full-precision product plus log2(window) growth bits
  function automatic int unsigned acc_width(input int unsigned width, input int unsigned window);
    return width + 1 + $clog2(window);
  endfunction

endpackage

// File: rtl/moving_sum.sv
// Exact running sum of the last WINDOW signed inputs, advancing only when en is high.
`timescale 1ns/1ps
module moving_sum #(
  parameter int unsigned WIDTH  = 33,
  parameter int unsigned WINDOW = 32
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     en,
  input  logic signed [WIDTH-1:0]                  din,
  output logic signed [WIDTH+$clog2(WINDOW)-1:0]   sum
);

  localparam int unsigned AW = $clog2(WINDOW);
  localparam int unsigned SW = WIDTH + AW;

  logic signed [WIDTH-1:0] hist [WINDOW];
  logic [AW-1:0]           ptr;
  logic signed [SW-1:0]    sum_n;

  // Intermediate wrap is harmless: the true windowed sum always fits in SW bits
  always_comb begin
    sum_n = sum + SW'(din) - SW'(hist[ptr]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(WINDOW); k++) hist[k] <= '0;
      ptr <= '0;
      sum <= '0;
    end else if (en) begin
      hist[ptr] <= din;
      ptr       <= ptr + AW'(1);
      sum       <= sum_n;
    end
  end

endmodule

// File: rtl/short_preamble_detector.sv
// Short-preamble detector: lag autocorrelation vs. windowed power, plateau FSM, o_tlast marker.
`timescale 1ns/1ps
module short_preamble_detector
  import ofdm_sync_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned LAG         = 16,
  parameter int unsigned WINDOW      = 32,
  parameter int unsigned THRESH_NUM  = 6,
  parameter int unsigned MIN_POWER   = 2**20,
  parameter int unsigned MIN_PLATEAU = 64,
  parameter int unsigned HOLDOFF     = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready
);

  localparam int unsigned H           = WIDTH / 2;
  localparam int unsigned PW          = WIDTH + 1;
  localparam int unsigned ACC_W       = acc_width(WIDTH, WINDOW);
  localparam int unsigned CW          = ACC_W + 4;
  localparam int unsigned LAG_AW      = (LAG > 1) ? $clog2(LAG) : 1;
  localparam int unsigned RW          = $clog2(MIN_PLATEAU + 1);
  localparam int unsigned HW          = $clog2(HOLDOFF + 1);
  localparam int unsigned PROD_STAGES = METRIC_DELAY - 2;

  logic beat;
  logic unused;

  assign o_tdata  = i_tdata;
  assign o_tvalid = i_tvalid;
  assign i_tready = o_tready;
  assign beat     = i_tvalid & o_tready;
  assign unused   = i_tlast;

  // Lag delay line as a circular buffer; the slot about to be overwritten holds x[n-LAG]
  logic [WIDTH-1:0]  dline [LAG];
  logic [LAG_AW-1:0] dptr;
  logic [WIDTH-1:0]  xd;

  assign xd = dline[dptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(LAG); k++) dline[k] <= '0;
      dptr <= '0;
    end else if (beat) begin
      dline[dptr] <= i_tdata;
      dptr        <= (dptr == LAG_AW'(LAG - 1)) ? '0 : dptr + LAG_AW'(1);
    end
  end

  // c = x[n]*conj(x[n-LAG]) and p = |x[n-LAG]|^2 at full precision
  logic signed [H-1:0]     xi, xq, di, dq;
  logic signed [WIDTH-1:0] p_ii, p_qq, p_qi, p_iq, p_di, p_dq;
  logic signed [PW-1:0]    re_c, im_c, pw_c;

  always_comb begin
    xi   = i_tdata[WIDTH-1:H];
    xq   = i_tdata[H-1:0];
    di   = xd[WIDTH-1:H];
    dq   = xd[H-1:0];
    p_ii = WIDTH'(xi) * WIDTH'(di);
    p_qq = WIDTH'(xq) * WIDTH'(dq);
    p_qi = WIDTH'(xq) * WIDTH'(di);
    p_iq = WIDTH'(xi) * WIDTH'(dq);
    p_di = WIDTH'(di) * WIDTH'(di);
    p_dq = WIDTH'(dq) * WIDTH'(dq);
    re_c = PW'(p_ii) + PW'(p_qq);
    im_c = PW'(p_qi) - PW'(p_iq);
    pw_c = PW'(p_di) + PW'(p_dq);
  end

  logic signed [PW-1:0] re_pipe [PROD_STAGES];
  logic signed [PW-1:0] im_pipe [PROD_STAGES];
  logic signed [PW-1:0] pw_pipe [PROD_STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(PROD_STAGES); k++) begin
        re_pipe[k] <= '0;
        im_pipe[k] <= '0;
        pw_pipe[k] <= '0;
      end
    end else if (beat) begin
      re_pipe[0] <= re_c;
      im_pipe[0] <= im_c;
      pw_pipe[0] <= pw_c;
      for (int k = 1; k < int'(PROD_STAGES); k++) begin
        re_pipe[k] <= re_pipe[k-1];
        im_pipe[k] <= im_pipe[k-1];
        pw_pipe[k] <= pw_pipe[k-1];
      end
    end
  end

  logic signed [ACC_W-1:0] acc_re, acc_im, acc_p;

  moving_sum #(.WIDTH(PW), .WINDOW(WINDOW)) u_sum_re (
    .clk(clk), .reset(reset), .en(beat), .din(re_pipe[PROD_STAGES-1]), .sum(acc_re)
  );

  moving_sum #(.WIDTH(PW), .WINDOW(WINDOW)) u_sum_im (
    .clk(clk), .reset(reset), .en(beat), .din(im_pipe[PROD_STAGES-1]), .sum(acc_im)
  );

  moving_sum #(.WIDTH(PW), .WINDOW(WINDOW)) u_sum_p (
    .clk(clk), .reset(reset), .en(beat), .din(pw_pipe[PROD_STAGES-1]), .sum(acc_p)
  );

  // |C| ~ max + min/4, then 8*|C| >= THRESH_NUM*P gated by a minimum power
  logic [ACC_W-1:0] abs_re, abs_im, mx, mn, mag;
  logic [CW-1:0]    lhs, rhs;
  logic             hit;

  always_comb begin
    abs_re = acc_re[ACC_W-1] ? ACC_W'(-acc_re) : ACC_W'(acc_re);
    abs_im = acc_im[ACC_W-1] ? ACC_W'(-acc_im) : ACC_W'(acc_im);
    mx     = (abs_re >= abs_im) ? abs_re : abs_im;
    mn     = (abs_re >= abs_im) ? abs_im : abs_re;
    mag    = mx + (mn >> 2);
    lhs    = CW'({mag, 3'b000});
    rhs    = CW'(THRESH_NUM) * CW'($unsigned(acc_p));
    hit    = (lhs >= rhs) && (CW'($unsigned(acc_p)) >= CW'(MIN_POWER));
  end

  sync_state_t   state, state_n;
  logic [RW-1:0] run, run_n;
  logic [HW-1:0] hcnt, hcnt_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      run     <= '0;
      hcnt    <= '0;
      o_tlast <= 1'b0;
    end else if (beat) begin
      state   <= state_n;
      run     <= run_n;
      hcnt    <= hcnt_n;
      o_tlast <= (state_n == S_MARK);
    end
  end

  always_comb begin
    state_n = state;
    run_n   = run;
    hcnt_n  = hcnt;
    unique case (state)
      S_IDLE: begin
        if (hit) begin
          state_n = S_PLATEAU;
          run_n   = RW'(1);
        end
      end
      S_PLATEAU: begin
        if (hit) begin
          if (run < RW'(MIN_PLATEAU)) run_n = run + RW'(1);
        end else begin
          state_n = (run >= RW'(MIN_PLATEAU)) ? S_MARK : S_IDLE;
          run_n   = '0;
        end
      end
      S_MARK: begin
        state_n = S_HOLDOFF;
        hcnt_n  = '0;
      end
      S_HOLDOFF: begin
        if (hcnt == HW'(HOLDOFF - 1)) begin
          state_n = S_IDLE;
          hcnt_n  = '0;
        end else begin
          hcnt_n = hcnt + HW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
